// File: rtl/modexp_datapath.sv
// Multiply-then-reduce datapath for modular exponentiation. It executes one
// controller strobe per cycle and publishes base^exponent mod modulus on done.
module modexp_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             initialize,
  input  logic             en_multiply,
  input  logic             en_modulo,
  input  logic             done,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic             is_multiplication_done,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             error
);

  localparam logic [WIDTH-1:0] one_w = WIDTH'(1);

  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   mod_reg;
  logic [WIDTH-1:0]   count;
  logic [2*WIDTH-1:0] prod;

  logic               mod_zero;
  logic [WIDTH-1:0]   base_red;
  logic [WIDTH-1:0]   acc_red;

  // A zero modulus bypasses both dividers so nothing ever divides by zero.
  assign mod_zero = (modulus == '0);
  assign base_red = mod_zero ? '0 : (base % modulus);
  assign acc_red  = (mod_reg == '0) ? '0
                  : WIDTH'(prod % {{WIDTH{1'b0}}, mod_reg});

  assign is_multiplication_done = (count == '0) || error;

  // Strobes are single-cycle commands with no backpressure; when several are
  // high together only the highest priority one acts:
  // initialize > done > en_multiply > en_modulo.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      b_reg        <= '0;
      mod_reg      <= '0;
      count        <= '0;
      prod         <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (initialize) begin
        mod_reg <= modulus;
        b_reg   <= base_red;
        acc     <= (modulus > one_w) ? one_w : '0;
        count   <= exponent;
        prod    <= '0;
        error   <= mod_zero;
      end else if (done) begin
        result       <= error ? '0 : acc;
        result_valid <= 1'b1;
      end else if (en_multiply) begin
        // Once the exponent is exhausted the count must not wrap.
        if (!is_multiplication_done) begin
          prod  <= (2*WIDTH)'(acc) * (2*WIDTH)'(b_reg);
          count <= count - one_w;
        end
      end else if (en_modulo) begin
        if (!error) begin
          acc <= acc_red;
        end
      end
    end
  end

endmodule

// File: tb/tb_modexp_datapath.sv
// Self-checking bench for modexp_datapath: drives the controller schedule and
// compares against a square-and-multiply reference model.
module tb_modexp_datapath;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        initialize;
  logic        en_multiply;
  logic        en_modulo;
  logic        done;
  logic [31:0] base;
  logic [31:0] exponent;
  logic [31:0] modulus;
  logic        is_multiplication_done;
  logic [31:0] result;
  logic        result_valid;
  logic        error;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] last_result = '0;

  modexp_datapath #(.WIDTH(32)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .initialize             (initialize),
    .en_multiply            (en_multiply),
    .en_modulo              (en_modulo),
    .done                   (done),
    .base                   (base),
    .exponent               (exponent),
    .modulus                (modulus),
    .is_multiplication_done (is_multiplication_done),
    .result                 (result),
    .result_valid           (result_valid),
    .error                  (error)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  // Reference: binary exponentiation with 64-bit intermediates.
  function automatic logic [31:0] model(input logic [31:0] b, input logic [31:0] e,
                                        input logic [31:0] m);
    longint unsigned r, x, mm;
    logic [31:0] k;
    if (m <= 32'd1) return 32'd0;
    mm = m;
    r  = 1;
    x  = b % mm;
    k  = e;
    while (k != 0) begin
      if (k[0]) r = (r * x) % mm;
      x = (x * x) % mm;
      k = k >> 1;
    end
    return r[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic strobe_pair();
    en_multiply = 1'b1;
    @(negedge clk);
    en_multiply = 1'b0;
    en_modulo   = 1'b1;
    @(negedge clk);
    en_modulo   = 1'b0;
  endtask

  // Full controller schedule for one exponentiation.
  task automatic run_op(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m,
                        input bit init_with_done, input string tag);
    logic [31:0] exp_r;
    logic        exp_err;
    int          e_eff, steps, t0, lat;
    exp_r   = model(b, e, m);
    exp_err = (m == 32'd0);
    e_eff   = exp_err ? 0 : int'(e);
    @(negedge clk);
    base = b; exponent = e; modulus = m;
    initialize = 1'b1;
    done       = init_with_done;
    t0 = cyc;
    @(negedge clk);
    initialize = 1'b0;
    done       = 1'b0;
    base = $urandom; exponent = $urandom; modulus = $urandom;
    chk({tag, ":error_t1"}, error, exp_err);
    chk({tag, ":imd_t1"}, is_multiplication_done, (e_eff == 0));
    chk({tag, ":result_kept_t1"}, result, last_result);
    if (init_with_done) chk({tag, ":rv_after_init_done"}, result_valid, 1'b0);
    steps = 0;
    while (!is_multiplication_done && steps < 300) begin
      strobe_pair();
      steps++;
    end
    chk({tag, ":steps"}, steps, e_eff);
    chk({tag, ":imd_end"}, is_multiplication_done, 1'b1);
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    for (int k = 0; k < 4 && result_valid !== 1'b1; k++) @(negedge clk);
    lat = cyc - t0;
    chk({tag, ":rv"}, result_valid, 1'b1);
    chk({tag, ":latency"}, lat, 2 * e_eff + 3);
    chk({tag, ":result"}, result, exp_r);
    chk({tag, ":error"}, error, exp_err);
    @(negedge clk);
    chk({tag, ":rv_pulse"}, result_valid, 1'b0);
    chk({tag, ":result_hold"}, result, exp_r);
    last_result = exp_r;
  endtask

  initial begin
    logic [31:0] rb, re, rm;
    int          sel;
    rst_n = 1'b0;
    initialize = 1'b0; en_multiply = 1'b0; en_modulo = 1'b0; done = 1'b0;
    base = '0; exponent = '0; modulus = '0;
    repeat (3) @(negedge clk);
    chk("rst:result", result, 32'd0);
    chk("rst:rv", result_valid, 1'b0);
    chk("rst:error", error, 1'b0);
    chk("rst:imd", is_multiplication_done, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst:imd", is_multiplication_done, 1'b1);

    run_op(32'd4, 32'd13, 32'd497, 1'b0, "nominal");
    chk("nominal:value", result, 32'd445);
    run_op(32'd7, 32'd0, 32'd10, 1'b0, "exp0_mod10");
    run_op(32'd7, 32'd0, 32'd1, 1'b0, "exp0_mod1");
    run_op(32'd5, 32'd9, 32'd0, 1'b0, "mod0");
    run_op(32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFF, 1'b0, "wide");
    run_op(32'd100, 32'd3, 32'd7, 1'b0, "base_ge_mod");

    // Extra multiply at count 0 must not touch prod: reduce/publish stays 1.
    @(negedge clk);
    en_multiply = 1'b1;
    @(negedge clk);
    en_multiply = 1'b0;
    chk("mul_at_zero:imd", is_multiplication_done, 1'b1);
    en_modulo = 1'b1;
    @(negedge clk);
    en_modulo = 1'b0;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("mul_at_zero:rv", result_valid, 1'b1);
    chk("mul_at_zero:result", result, 32'd1);
    @(negedge clk);

    // Reset during the fifth multiply of the nominal case.
    base = 32'd4; exponent = 32'd13; modulus = 32'd497;
    initialize = 1'b1;
    @(negedge clk);
    initialize = 1'b0;
    repeat (4) strobe_pair();
    en_multiply = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst:result", result, 32'd0);
    chk("midrst:rv", result_valid, 1'b0);
    chk("midrst:error", error, 1'b0);
    chk("midrst:imd", is_multiplication_done, 1'b1);
    @(negedge clk);
    en_multiply = 1'b0;
    rst_n = 1'b1;
    last_result = '0;
    en_modulo = 1'b1;
    @(negedge clk);
    en_modulo = 1'b0;
    @(negedge clk);
    chk("midrst:idle_imd", is_multiplication_done, 1'b1);
    chk("midrst:idle_result", result, 32'd0);
    run_op(32'd4, 32'd13, 32'd497, 1'b0, "after_rst");

    run_op(32'd3, 32'd5, 32'd11, 1'b1, "init_with_done");

    for (int i = 0; i < 20; i++) begin
      rb  = $urandom;
      re  = $urandom_range(0, 12);
      sel = $urandom_range(0, 9);
      if (sel == 0)      rm = 32'd0;
      else if (sel == 1) rm = 32'd1;
      else if (sel < 5)  rm = $urandom_range(2, 1000);
      else               rm = $urandom;
      run_op(rb, re, rm, bit'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
